// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: shared pipeline definitions (MA state encoding, ack timeout default)
package memory_access_stage_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} ma_state_t;
    localparam int MA_TIMEOUT = 255;
endpackage

// File: rtl/memory_access_stage_wait_counter.sv
// ma_wait_counter: counts WAIT cycles without ack, flags the cycle at which the timeout edge fires
module ma_wait_counter
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = MA_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
    // tc is high in the last WAIT cycle, so the counter reaches TIMEOUT on the exit edge
    assign tc = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: EX/MA -> MA/WB stage with a two-state data-memory handshake and ack timeout
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = MA_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        isld_in,
    input  logic        isst_in,
    input  logic        iswb_in,
    input  logic        iscall_in,
    input  logic [3:0]  rd_in,
    input  logic [31:0] aluresult_in,
    input  logic [31:0] op2_in,
    input  logic [31:0] pc_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        valid_out,
    output logic        iswb,
    output logic        iscall,
    output logic        isld,
    output logic [3:0]  rd,
    output logic [31:0] aluresult1,
    output logic [31:0] ldresult,
    output logic [31:0] pc_current,
    output logic        mem_err
);
    ma_state_t st, st_nxt;
    logic        in_wait, accept, alu_go, done, tc;
    logic        l_wb, l_call, l_ld, l_st;
    logic [3:0]  l_rd;
    logic [31:0] l_addr, l_data, l_pc;

    assign in_wait = st == WAIT;
    assign accept  = !in_wait && valid_in && (isld_in || isst_in);
    assign alu_go  = !in_wait && valid_in && !isld_in && !isst_in;
    assign done    = in_wait && (mem_ack || tc);

    assign stall_out = in_wait;
    assign mem_req   = in_wait;
    assign mem_we    = in_wait && l_st;
    assign mem_addr  = in_wait ? l_addr : '0;
    assign mem_wdata = in_wait ? l_data : '0;

    ma_wait_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (in_wait && !mem_ack),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        st_nxt = in_wait ? (done ? IDLE : WAIT) : (accept ? WAIT : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_rd   <= '0;
            l_wb   <= 1'b0;
            l_call <= 1'b0;
            l_ld   <= 1'b0;
            l_st   <= 1'b0;
            l_addr <= '0;
            l_data <= '0;
            l_pc   <= '0;
        end else if (accept) begin
            l_rd   <= rd_in;
            l_wb   <= iswb_in;
            l_call <= iscall_in;
            l_ld   <= isld_in;
            l_st   <= isst_in;
            l_addr <= aluresult_in;
            l_data <= op2_in;
            l_pc   <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            iswb       <= 1'b0;
            iscall     <= 1'b0;
            isld       <= 1'b0;
            rd         <= '0;
            aluresult1 <= '0;
            ldresult   <= '0;
            pc_current <= '0;
            mem_err    <= 1'b0;
        end else begin
            valid_out <= alu_go || done;
            mem_err   <= mem_err || (in_wait && tc && !mem_ack);
            if (alu_go) begin
                iswb       <= iswb_in;
                iscall     <= iscall_in;
                isld       <= 1'b0;
                rd         <= rd_in;
                aluresult1 <= aluresult_in;
                ldresult   <= '0;
                pc_current <= pc_in;
            end else if (done) begin
                // a timed-out op still retires, but must not write back or return data
                iswb       <= l_wb && !l_st && mem_ack;
                iscall     <= l_call;
                isld       <= l_ld;
                rd         <= l_rd;
                aluresult1 <= l_addr;
                ldresult   <= (mem_ack && l_ld && !l_st) ? mem_rdata : '0;
                pc_current <= l_pc;
            end
        end
    end
endmodule
